// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer: FSM states,
// prefix bytes, the discard-byte list and the packed key-event record.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Protocol bytes (BAT result, echo, ACK, resend, error, pause lead-in).
  localparam int PS2_NUM_DISCARD = 7;
  localparam logic [PS2_NUM_DISCARD*8-1:0] PS2_DISCARD_LIST = {
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1
  };

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  function automatic logic ps2_is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_DISCARD; i++) begin
      if (PS2_DISCARD_LIST[i*8 +: 8] == b) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_scancode_ctrl_fifo.sv
// ps2_evt_fifo: synchronous FIFO of key events. Full/empty come from the
// occupancy count; pointers wrap naturally over a power-of-two depth.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  ps2_evt_t                     push_evt,
  input  logic                         pop,
  output ps2_evt_t                     head,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  ps2_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            empty;
  logic            full;
  logic            pop_en;
  logic            push_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees the slot in the same edge, so a full FIFO still takes a push
  // when the head is being consumed.
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign drop    = push && full && !pop_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_evt;
  end

  // Head reads as zero while empty so the event fields have a defined reset value.
  assign head_valid = !empty;
  assign head       = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// ps2_scancode_ctrl: turns the raw PS/2 byte stream into {ext, brk, code} key
// events buffered in a FIFO. Optional make-repeat filter: PS2_TYPEMATIC_FILTER_EN.
module ps2_scancode_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        keycode,
  input  logic                              key_valid,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [7:0]                        evt_code,
  output logic                              evt_ext,
  output logic                              evt_brk,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  input  logic                              overflow_clr
);

  localparam int TW = $clog2(TIMEOUT_CYC+1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  ps2_state_e      state;
  ps2_state_e      state_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic [TW-1:0]   tmo_nxt;
  logic            is_ext_b;
  logic            is_brk_b;
  logic            is_data;
  logic            tmo_hit;
  logic            emit;
  ps2_evt_t        evt;
  logic            push;
  logic            drop;
  ps2_evt_t        head;

  assign is_ext_b = key_valid && (keycode == PS2_EXT);
  assign is_brk_b = key_valid && (keycode == PS2_BRK);
  assign is_data  = key_valid && !is_ext_b && !is_brk_b && !ps2_is_discard(keycode);

  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit  = (state != ST_IDLE) && !key_valid && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (is_ext_b) begin
      case (state)
        ST_IDLE: state_nxt = ST_EXT;
        ST_BRK:  state_nxt = ST_EXT_BRK;
        default: state_nxt = state;
      endcase
    end else if (is_brk_b) begin
      case (state)
        ST_IDLE: state_nxt = ST_BRK;
        ST_EXT:  state_nxt = ST_EXT_BRK;
        default: state_nxt = state;
      endcase
    end else if (is_data || tmo_hit) begin
      state_nxt = ST_IDLE;
    end
  end

  // Discard bytes freeze the counter; only byte-free cycles age a prefix.
  always_comb begin
    tmo_nxt = tmo_cnt;
    if (is_ext_b || is_brk_b || state_nxt == ST_IDLE) begin
      tmo_nxt = '0;
    end else if (!key_valid) begin
      tmo_nxt = tmo_cnt + TW'(1);
    end
  end

  always_comb begin
    evt      = '0;
    emit     = is_data;
    evt.ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
    evt.brk  = (state == ST_BRK) || (state == ST_EXT_BRK);
    evt.code = keycode;
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic        lm_valid;
  logic [8:0]  lm_key;
  logic        lm_match;

  assign lm_match = lm_valid && (lm_key == {evt.ext, evt.code});
  assign push     = emit && (evt.brk || !lm_match);

  // Held keys repeat their make code; only the first make of a press is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lm_valid <= 1'b0;
      lm_key   <= '0;
    end else if (emit) begin
      if (!evt.brk) begin
        if (!lm_match) begin
          lm_valid <= 1'b1;
          lm_key   <= {evt.ext, evt.code};
        end
      end else if (lm_match) begin
        lm_valid <= 1'b0;
      end
    end
  end
`else
  assign push = emit;
`endif

  // Output handshake: an event transfers on a rising edge where evt_valid and
  // evt_ready are both high; the head is held stable until that edge, and
  // evt_ready has no effect while evt_valid is low.
  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_evt   (evt),
    .pop        (evt_ready),
    .head       (head),
    .head_valid (evt_valid),
    .count      (fifo_count),
    .drop       (drop)
  );

  assign evt_code = head.code;
  assign evt_ext  = head.ext;
  assign evt_brk  = head.brk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/ps2_scancode_ctrl.md
# ps2_scancode_ctrl

Sequences the raw byte stream from the PS/2 keyboard receiver into complete key events. Consumes the 8-bit `keycode` / one-cycle `key_valid` strobe, resolves the 0xE0 (extended) and 0xF0 (break) prefix bytes with a state machine, and discards protocol bytes. Completed events are buffered in a small FIFO behind a valid/ready handshake for the game/display logic downstream.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; power of two, at least 2.
- `TIMEOUT_CYC`, default 100000: `clk` cycles a prefix state may wait for its next byte.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `keycode`  in  8  byte from the receiver; sampled only while `key_valid` is high.
- `key_valid`  in  1  one-cycle strobe marking a new byte.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head event.
- `evt_code`  out  8  scan code of the head event.
- `evt_ext`  out  1  head event was 0xE0-prefixed.
- `evt_brk`  out  1  head event is a release (0xF0-prefixed).
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  occupied entries.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.
- `overflow_clr`  in  1  clears `overflow`.

## Operation
- FSM states: IDLE, EXT, BRK, EXT_BRK; reset state IDLE.
- Byte handling on `key_valid`:
  - 0xE0: IDLE→EXT, BRK→EXT_BRK; EXT and EXT_BRK hold.
  - 0xF0: IDLE→BRK, EXT→EXT_BRK; BRK and EXT_BRK hold.
  - Discard bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF, 0xE1: dropped; state and timeout counter unchanged.
  - Any other byte: emit event {ext = state∈{EXT,EXT_BRK}, brk = state∈{BRK,EXT_BRK}, code = byte}; state→IDLE.
- Timeout: a counter clears on every accepted prefix byte and increments each cycle in non-IDLE states. At TIMEOUT_CYC it forces the state to IDLE with no event. The counter is held at 0 in IDLE.
- FIFO:
  - A push happens on event emit; a pop happens when `evt_valid && evt_ready`.
  - When full, a push with no pop in the same cycle drops the event and sets `overflow`.
  - When full, a simultaneous push and pop are both accepted; count is unchanged.
  - When empty, `evt_ready` is ignored.
- Wrap-around: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from `fifo_count`.
- Output hold: `evt_code/ext/brk` stay stable while `evt_valid && !evt_ready`.
- `overflow`: if `overflow_clr` and a new drop occur in the same cycle, the set wins.
- Reset values: `evt_valid`=0, `evt_code`=0x00, `evt_ext`=0, `evt_brk`=0, `fifo_count`=0, `overflow`=0. FSM→IDLE, timeout counter→0, pointers→0.
- Reset mid-sequence, or with the FIFO non-empty: all partial prefixes and buffered events are lost.

## Timing
- `key_valid` on the final byte at cycle N: the push is at edge N+1, and `evt_valid` is high in cycle N+1 if the FIFO was empty. Latency is one cycle.
- Pop at the edge where `evt_valid && evt_ready`: the next entry is presented in the following cycle, which gives back-to-back throughput of one event per cycle.
- `fifo_count` and `overflow` update at the same edge as the push or pop.
- Timeout fires at the edge where the counter equals TIMEOUT_CYC-1. If a `key_valid` arrives in that same cycle, the byte is processed normally and the timeout is suppressed.

## Configuration
- Macro: `PS2_TYPEMATIC_FILTER_EN`.
- Defined:
  - A `last_make` register holds {ext, code} plus a valid bit.
  - A make event equal to `last_make` is suppressed (no push, no overflow).
  - Any other make updates `last_make`.
  - A break matching `last_make` clears its valid bit.
  - All break events are always pushed.
- Undefined: every make is pushed, including typematic repeats, and the `last_make` logic is absent.

## Structure
- Package `ps2_pkg`:
  - FSM state enum.
  - Constants PS2_EXT (0xE0), PS2_BRK (0xF0), and the discard-byte list.
  - Packed event struct {ext, brk, code[7:0]}, 10 bits.
- Sub-module `ps2_evt_fifo`: synchronous FIFO of event structs with push/pop/count, parameterised by FIFO_DEPTH. The FSM, timeout and filter stay in `ps2_scancode_ctrl`.

## Test plan
- Byte 0x1C with `evt_ready`=1 → one event {ext0, brk0, 0x1C}, `evt_valid` high one cycle after the strobe.
- Sequence E0 F0 75 → one event {ext1, brk1, 0x75}; F0 1C → {ext0, brk1, 0x1C}; no events emitted for the prefix bytes.
- 0xE0, then TIMEOUT_CYC idle cycles, then 0x1C → {ext0, brk0, 0x1C}. 0xAA/0xFA injected mid-prefix → ignored, prefix preserved.
- `evt_ready`=0, FIFO_DEPTH+1 makes → `fifo_count`=FIFO_DEPTH and `overflow`=1, with the oldest 8 retained in order. Then `overflow_clr` → 0; on drain, the codes are in order.
- Full FIFO, push and pop in the same cycle → count stays FIFO_DEPTH, `overflow` stays 0.
- With `PS2_TYPEMATIC_FILTER_EN`: 1C 1C 1C F0 1C 1C → events make 1C, break 1C, make 1C. Without the macro → five make events plus one break.
